// File: rtl/bcd_counter_scan_display.sv
// Four-digit BCD up/down counter driven by the prescaler tick, with a
// time-multiplexed common-anode 7-segment scanner.
module bcd_counter_scan_display #(
  parameter int SCAN_DIV = 100000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_i,
  input  logic        en_i,
  input  logic        up_i,
  input  logic        clr_i,
  output logic [15:0] count_o,
  output logic        wrap_o,
  output logic [3:0]  an_o,
  output logic [6:0]  seg_o
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (c) begin
        if (v[4*k +: 4] == 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (b) begin
        if (v[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Active-low gfedcba; non-BCD nibbles decode to blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // Stage 0: count register and scan timebase
  logic [SW-1:0] scan_cnt_p0;
  logic [1:0]    idx_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_o <= 16'h0000;
      wrap_o  <= 1'b0;
    end else if (clr_i) begin
      count_o <= 16'h0000;
      wrap_o  <= 1'b0;
    end else if (tick_i && en_i) begin
      if (up_i) begin
        count_o <= bcd_inc(count_o);
        wrap_o  <= (count_o == 16'h9999);
      end else begin
        count_o <= bcd_dec(count_o);
        wrap_o  <= (count_o == 16'h0000);
      end
    end else begin
      wrap_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_p0 <= '0;
      idx_p0      <= 2'd0;
    end else if (scan_cnt_p0 == SCAN_LAST) begin
      scan_cnt_p0 <= '0;
      idx_p0      <= idx_p0 + 2'd1;
    end else begin
      scan_cnt_p0 <= scan_cnt_p0 + 1'b1;
    end
  end

  // Stage 1: digit select, leading-zero blanking, registered anode/segments
  logic [3:0] digit_p0;
  logic [3:0] lz_p0;
  logic       blank_p0;

  always_comb begin
    digit_p0 = count_o[{idx_p0, 2'b00} +: 4];
    lz_p0[3] = (count_o[15:12] == 4'd0);
    lz_p0[2] = lz_p0[3] && (count_o[11:8] == 4'd0);
    lz_p0[1] = lz_p0[2] && (count_o[7:4] == 4'd0);
    lz_p0[0] = 1'b0;
    blank_p0 = BLANK_LZ && lz_p0[idx_p0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_o  <= 4'b1111;
      seg_o <= 7'b1111111;
    end else begin
      an_o  <= ~(4'b0001 << idx_p0);
      seg_o <= blank_p0 ? 7'b1111111 : seg_decode(digit_p0);
    end
  end

endmodule

// File: tb/tb_bcd_counter_scan_display.sv
// Bench for bcd_counter_scan_display: directed and random steps checked each
// cycle against an integer-arithmetic reference model.
module tb_bcd_counter_scan_display;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_i, en_i, up_i, clr_i;
  logic [15:0] count_o;
  logic        wrap_o;
  logic [3:0]  an_o;
  logic [6:0]  seg_o;

  bcd_counter_scan_display #(.SCAN_DIV(SCAN_DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .tick_i(tick_i), .en_i(en_i), .up_i(up_i),
    .clr_i(clr_i), .count_o(count_o), .wrap_o(wrap_o), .an_o(an_o), .seg_o(seg_o)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Model state: decimal count and number of edges since reset release
  int   m_n;
  int   m_e;
  bit   m_wrap;
  logic [6:0] seg_tab [0:9];

  function automatic int pow10(input int k);
    case (k)
      0: return 1;
      1: return 10;
      2: return 100;
      default: return 1000;
    endcase
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    return 16'(((n / 1000) % 10) * 4096 + ((n / 100) % 10) * 256 +
               ((n / 10) % 10) * 16 + (n % 10));
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called in the low clock phase; applies inputs, models one edge, checks, returns at negedge.
  task automatic cyc(input bit t, input bit e, input bit u, input bit c);
    int n0, idx, dig;
    bit blank;
    logic [3:0] an_x;
    logic [6:0] seg_x;
    tick_i = t; en_i = e; up_i = u; clr_i = c;
    @(posedge clk);
    n0  = m_n;
    idx = (m_e / SCAN_DIV) % 4;
    m_e++;
    dig   = (n0 / pow10(idx)) % 10;
    blank = (idx > 0) && (n0 < pow10(idx));
    an_x  = ~(4'b0001 << idx);
    seg_x = blank ? 7'b1111111 : seg_tab[dig];
    if (c) begin
      m_n = 0; m_wrap = 0;
    end else if (t && e) begin
      if (u) begin
        m_wrap = (n0 == 9999); m_n = (n0 + 1) % 10000;
      end else begin
        m_wrap = (n0 == 0);    m_n = (n0 + 9999) % 10000;
      end
    end else begin
      m_wrap = 0;
    end
    #1;
    chk("count", count_o, to_bcd(m_n));
    chk("wrap", 16'(wrap_o), 16'(m_wrap));
    chk("an", 16'(an_o), 16'(an_x));
    chk("seg", 16'(seg_o), 16'(seg_x));
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, count_o, 16'h0000);
    chk({tag, "_wrap"}, 16'(wrap_o), 16'h0000);
    chk({tag, "_an"}, 16'(an_o), 16'h000f);
    chk({tag, "_seg"}, 16'(seg_o), 16'h007f);
  endtask

  task automatic ticks(input int n, input bit u);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, u, 1'b0);
  endtask

  initial begin
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;
    rst = 1'b1; tick_i = 0; en_i = 0; up_i = 0; clr_i = 0;
    m_n = 0; m_e = 0; m_wrap = 0;
    #1;
    chk_reset_vals("rst0");
    @(negedge clk);
    @(negedge clk);
    chk_reset_vals("rst_hold");
    rst = 1'b0;

    // First scan steps after release
    cyc(0, 0, 0, 0);
    chk("first_an", 16'(an_o), 16'h000e);
    chk("first_seg", 16'(seg_o), 16'(7'b1000000));
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);
    chk("scan2_an", 16'(an_o), 16'h000d);
    chk("scan2_seg", 16'(seg_o), 16'(7'b1111111));

    // Down to 9998 (wrap on the first), then up through 9999 to 0000
    ticks(1, 0);
    chk("dn_wrap", 16'(wrap_o), 16'h0001);
    ticks(1, 0);
    chk("at9998", count_o, 16'h9998);
    ticks(1, 1);
    chk("at9999", count_o, 16'h9999);
    chk("no_wrap", 16'(wrap_o), 16'h0000);
    ticks(1, 1);
    chk("up_wrap_cnt", count_o, 16'h0000);
    chk("up_wrap", 16'(wrap_o), 16'h0001);
    cyc(0, 1, 1, 0);
    chk("wrap_one_cycle", 16'(wrap_o), 16'h0000);

    // Borrow chain from 1000
    ticks(1000, 1);
    chk("at1000", count_o, 16'h1000);
    ticks(1, 0);
    chk("borrow0999", count_o, 16'h0999);
    ticks(1, 0);
    chk("at0998", count_o, 16'h0998);

    // Gating by en_i
    cyc(1, 0, 1, 0);
    cyc(1, 0, 0, 0);
    chk("gated", count_o, 16'h0998);

    // Clear beats a simultaneous tick
    cyc(0, 0, 0, 1);
    ticks(517, 1);
    chk("at0517", count_o, 16'h0517);
    cyc(1, 1, 1, 1);
    chk("clr_prio", count_o, 16'h0000);
    chk("clr_wrap", 16'(wrap_o), 16'h0000);

    // Scan walk at 1234
    ticks(1234, 1);
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, 0);

    // Randomized operation
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));

    // Async reset mid-scan at 0305
    cyc(0, 0, 0, 1);
    ticks(305, 1);
    chk("at0305", count_o, 16'h0305);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("async");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_n = 0; m_e = 0; m_wrap = 0;
    cyc(0, 0, 0, 0);
    chk("post_an", 16'(an_o), 16'h000e);
    chk("post_seg", 16'(seg_o), 16'(7'b1000000));
    ticks(3, 1);
    chk("restart", count_o, 16'h0003);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
